// File: rtl/xbus_pkg.sv
// Shared xbus definitions: bus widths, default responder decode and the responder FSM states.
package xbus_pkg;

   localparam int XBUS_ADDR_W = 22;
   localparam int XBUS_DATA_W = 32;
   localparam logic [13:0] XBUS_BASE_HI_DEFAULT = 14'h0010;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_ACK   = 2'd2,
      S_RECOV = 2'd3
   } xbus_state_e;

endpackage

// File: rtl/xbus_ram_array.sv
// 256 x 32 storage with one synchronous write port and one synchronous read port.
// Only the read data register is reset; the storage itself keeps its contents.
module xbus_ram_array
   import xbus_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   we,
   input  logic [7:0]             waddr,
   input  logic [XBUS_DATA_W-1:0] wdata,
   input  logic                   re,
   input  logic [7:0]             raddr,
   output logic [XBUS_DATA_W-1:0] rdata
);

   logic [XBUS_DATA_W-1:0] mem_q [256];
   logic [XBUS_DATA_W-1:0] rdata_q;
   logic [XBUS_DATA_W-1:0] rdata_d;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem_q[raddr];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/xbus_ram.sv
// xbus RAM responder: decodes addrin[21:8], waits WAIT cycles, acks once, then recovers one cycle.
// Define XBUS_RAM_STATS_EN to build the completed read/write counters.
module xbus_ram
   import xbus_pkg::*;
#(
   parameter logic [13:0] BASE_HI = XBUS_BASE_HI_DEFAULT,
   parameter int          WAIT    = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [XBUS_ADDR_W-1:0] addrin,
   input  logic [XBUS_DATA_W-1:0] datain,
   input  logic                   reqin,
   input  logic                   writein,
   output logic [XBUS_DATA_W-1:0] dataout,
   output logic                   ackout,
   output logic                   decodeout,
   output logic [15:0]            rd_count,
   output logic [15:0]            wr_count
);

   xbus_state_e            state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [7:0]             addr_q, addr_d;
   logic                   wr_q, wr_d;
   logic [XBUS_DATA_W-1:0] data_q, data_d;

   logic                   hit;
   logic                   mem_we;
   logic                   mem_re;
   logic [7:0]             mem_raddr;
   logic [XBUS_DATA_W-1:0] hold;

   assign hit       = reqin && (addrin[21:8] == BASE_HI);
   assign decodeout = hit;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wr_d    = wr_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE: begin
            if (hit) begin
               addr_d  = addrin[7:0];
               wr_d    = writein;
               data_d  = datain;
               cnt_d   = 4'(WAIT);
               state_d = (WAIT == 0) ? S_ACK : S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = S_ACK;
            end
         end
         S_ACK:   state_d = S_RECOV;
         S_RECOV: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         data_q  <= data_d;
      end
   end

   // With WAIT=0 the address has not been latched yet on the load edge, so read straight off the bus.
   assign mem_re    = (state_d == S_ACK) && (state_q != S_ACK);
   assign mem_raddr = (state_q == S_IDLE) ? addrin[7:0] : addr_q;
   assign mem_we    = (state_q == S_ACK) && wr_q && !reset;

   xbus_ram_array u_array (
      .clk   (clk),
      .reset (reset),
      .we    (mem_we),
      .waddr (addr_q),
      .wdata (data_q),
      .re    (mem_re),
      .raddr (mem_raddr),
      .rdata (hold)
   );

   assign ackout  = (state_q == S_ACK);
   assign dataout = ((state_q == S_ACK) && !wr_q) ? hold : '0;

`ifdef XBUS_RAM_STATS_EN
   logic [15:0] rd_count_q, rd_count_d;
   logic [15:0] wr_count_q, wr_count_d;

   always_comb begin
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
      if (state_q == S_ACK) begin
         if (wr_q) begin
            wr_count_d = wr_count_q + 16'd1;
         end else begin
            rd_count_d = rd_count_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_count_q <= '0;
         wr_count_q <= '0;
      end else begin
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;
`else
   assign rd_count = '0;
   assign wr_count = '0;
`endif

endmodule

// File: tb/tb_xbus_ram.sv
// Bench for xbus_ram: two responders (WAIT=2 and WAIT=0) share one bus and are compared every cycle
// against a transfer-level model; directed sequences pin the model with literal expectations.
module tb_xbus_ram;

   localparam logic [13:0] HI     = 14'h0010;
   localparam int          WAIT_A = 2;
   localparam int          WAIT_B = 0;

   logic        clk     = 1'b0;
   logic        reset   = 1'b0;
   logic [21:0] addrin  = '0;
   logic [31:0] datain  = '0;
   logic        reqin   = 1'b0;
   logic        writein = 1'b0;

   logic [31:0] dataout_a, dataout_b;
   logic        ackout_a, ackout_b;
   logic        decodeout_a, decodeout_b;
   logic [15:0] rd_count_a, rd_count_b;
   logic [15:0] wr_count_a, wr_count_b;

   xbus_ram #(.BASE_HI(HI), .WAIT(WAIT_A)) u_dut_a (
      .clk       (clk),
      .reset     (reset),
      .addrin    (addrin),
      .datain    (datain),
      .reqin     (reqin),
      .writein   (writein),
      .dataout   (dataout_a),
      .ackout    (ackout_a),
      .decodeout (decodeout_a),
      .rd_count  (rd_count_a),
      .wr_count  (wr_count_a)
   );

   xbus_ram #(.BASE_HI(HI), .WAIT(WAIT_B)) u_dut_b (
      .clk       (clk),
      .reset     (reset),
      .addrin    (addrin),
      .datain    (datain),
      .reqin     (reqin),
      .writein   (writein),
      .dataout   (dataout_b),
      .ackout    (ackout_b),
      .decodeout (decodeout_b),
      .rd_count  (rd_count_b),
      .wr_count  (wr_count_b)
   );

   always #5 clk = ~clk;

   int tb_cyc = 0;
   always @(posedge clk) tb_cyc <= tb_cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Transfer-level model: a captured request acks WAIT+1 cycles later and the responder is
   // free again two cycles after the ack. Storage persists across reset.
   logic [31:0] m_mem    [2][256];
   bit          m_valid  [2][256];
   int          m_ack_at [2] = '{-1, -1};
   int          m_free_at[2] = '{0, 0};
   logic [7:0]  m_addr   [2];
   logic [31:0] m_data   [2];
   bit          m_wr     [2];
   int          m_rd_n   [2] = '{0, 0};
   int          m_wr_n   [2] = '{0, 0};
   bit          model_on = 1'b0;

   logic        c_ack, c_dec, e_dec, e_ack;
   logic [31:0] c_dout;
   logic [15:0] c_rd, c_wr;

   always @(negedge clk) begin
      e_dec = reqin && (addrin[21:8] == HI);
      for (int k = 0; k < 2; k++) begin
         if (k == 0) begin
            c_ack = ackout_a; c_dec = decodeout_a; c_dout = dataout_a; c_rd = rd_count_a; c_wr = wr_count_a;
         end else begin
            c_ack = ackout_b; c_dec = decodeout_b; c_dout = dataout_b; c_rd = rd_count_b; c_wr = wr_count_b;
         end
         e_ack = (tb_cyc == m_ack_at[k]);
         if (model_on) begin
            check_output($sformatf("decodeout[%0d]", k), 32'(c_dec), 32'(e_dec));
            check_output($sformatf("ackout[%0d]", k), 32'(c_ack), 32'(e_ack));
            if (e_ack && !m_wr[k]) begin
               if (m_valid[k][m_addr[k]])
                  check_output($sformatf("dataout[%0d]", k), c_dout, m_mem[k][m_addr[k]]);
            end else begin
               check_output($sformatf("dataout_idle[%0d]", k), c_dout, 32'h0);
            end
`ifdef XBUS_RAM_STATS_EN
            check_output($sformatf("rd_count[%0d]", k), 32'(c_rd), 32'(m_rd_n[k] % 65536));
            check_output($sformatf("wr_count[%0d]", k), 32'(c_wr), 32'(m_wr_n[k] % 65536));
`else
            check_output($sformatf("rd_count[%0d]", k), 32'(c_rd), 32'h0);
            check_output($sformatf("wr_count[%0d]", k), 32'(c_wr), 32'h0);
`endif
         end
         if (reset) begin
            m_ack_at[k]  = -1;
            m_free_at[k] = 0;
            m_rd_n[k]    = 0;
            m_wr_n[k]    = 0;
         end else if (model_on) begin
            if (e_ack) begin
               if (m_wr[k]) begin
                  m_mem[k][m_addr[k]]   = m_data[k];
                  m_valid[k][m_addr[k]] = 1'b1;
                  m_wr_n[k]++;
               end else begin
                  m_rd_n[k]++;
               end
            end
            if (tb_cyc >= m_free_at[k] && e_dec) begin
               m_addr[k]    = addrin[7:0];
               m_data[k]    = datain;
               m_wr[k]      = writein;
               m_ack_at[k]  = tb_cyc + ((k == 0) ? WAIT_A : WAIT_B) + 1;
               m_free_at[k] = m_ack_at[k] + 2;
            end
         end
      end
      if (reset) model_on = 1'b1;
   end

   function automatic logic ack_of(input int k);
      return (k == 0) ? ackout_a : ackout_b;
   endfunction

   function automatic logic [31:0] dout_of(input int k);
      return (k == 0) ? dataout_a : dataout_b;
   endfunction

   function automatic logic dec_of(input int k);
      return (k == 0) ? decodeout_a : decodeout_b;
   endfunction

   task automatic apply_stimulus(input logic r, input logic q, input logic w,
                                 input logic [21:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      reset   = r;
      reqin   = q;
      writein = w;
      addrin  = a;
      datain  = d;
   endtask

   task automatic idle_gap(input int n);
      apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0);
      repeat (n) @(posedge clk);
   endtask

   task automatic do_xfer(input int k, input logic w, input logic [21:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd);
      int c0;
      bit seen;
      apply_stimulus(1'b0, 1'b1, w, a, d);
      @(negedge clk);
      c0   = tb_cyc;
      seen = 1'b0;
      lat  = -1;
      rd   = '0;
      check_output("decode_hit", 32'(dec_of(k)), 32'h1);
      for (int i = 0; i < 32 && !seen; i++) begin
         if (ack_of(k)) begin
            seen = 1'b1;
            lat  = tb_cyc - c0;
            rd   = dout_of(k);
         end else begin
            @(negedge clk);
         end
      end
      if (!seen) check_output("xfer_timeout", 32'h0, 32'h1);
      apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic b2b(input int k, input logic w, input int n, input bit chk);
      int last;
      bit seen;
      last = -1;
      for (int i = 0; i < n; i++) begin
         apply_stimulus(1'b0, 1'b1, w, {HI, 8'(i)}, 32'(i));
         seen = 1'b0;
         for (int j = 0; j < 32 && !seen; j++) begin
            @(negedge clk);
            if (ack_of(k)) seen = 1'b1;
         end
         if (!seen) check_output("b2b_timeout", 32'h0, 32'h1);
         else if (chk && last >= 0) check_output("b2b_gap", 32'(tb_cyc - last), 32'd3);
         last = tb_cyc;
      end
      apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          lat;
      logic [31:0] rd;
      int          acks;
      int          decs;
      logic [21:0] a;

      apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0);
      apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      check_output("reset_ack", 32'(ackout_a), 32'h0);
      check_output("reset_dout", dataout_a, 32'h0);
      check_output("reset_rd_count", 32'(rd_count_a), 32'h0);
      check_output("reset_wr_count", 32'(wr_count_b), 32'h0);
      idle_gap(2);

      $display("[TB] write then read 0x0a at WAIT=2");
      do_xfer(0, 1'b1, 22'o0010012, 32'hdeadbeef, lat, rd);
      check_output("write_latency", 32'(lat), 32'd3);
      idle_gap(6);
      do_xfer(0, 1'b0, 22'o0010012, 32'h0, lat, rd);
      check_output("read_latency", 32'(lat), 32'd3);
      check_output("read_data", rd, 32'hdeadbeef);
      idle_gap(6);

      $display("[TB] non-matching address held 20 cycles");
      apply_stimulus(1'b0, 1'b1, 1'b1, {14'h0011, 8'h0a}, 32'h55aa55aa);
      acks = 0;
      decs = 0;
      repeat (20) begin
         @(negedge clk);
         if (ackout_a || ackout_b) acks++;
         if (decodeout_a || decodeout_b) decs++;
      end
      check_output("miss_acks", 32'(acks), 32'h0);
      check_output("miss_decodes", 32'(decs), 32'h0);
      idle_gap(6);

      $display("[TB] back-to-back writes at WAIT=0");
      b2b(1, 1'b1, 4, 1'b1);
      idle_gap(6);
      for (int i = 0; i < 4; i++) begin
         do_xfer(1, 1'b0, {HI, 8'(i)}, 32'h0, lat, rd);
         check_output("b2b_readback", rd, 32'(i));
         idle_gap(6);
      end

      $display("[TB] reset during wait of a write");
      do_xfer(0, 1'b1, {HI, 8'h05}, 32'h0, lat, rd);
      idle_gap(6);
      apply_stimulus(1'b0, 1'b1, 1'b1, {HI, 8'h05}, 32'h12345678);
      @(negedge clk);
      @(negedge clk);
      apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0);
      apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0);
      acks = 0;
      repeat (8) begin
         @(negedge clk);
         if (ackout_a) acks++;
      end
      check_output("reset_abort_acks", 32'(acks), 32'h0);
      do_xfer(0, 1'b0, {HI, 8'h05}, 32'h0, lat, rd);
      check_output("reset_abort_data", rd, 32'h0);
      idle_gap(6);

      $display("[TB] random traffic");
      for (int i = 0; i < 3000; i++) begin
         a[21:8] = ($urandom_range(0, 7) == 0) ? HI + 14'd1 : HI;
         a[7:0]  = 8'($urandom_range(0, 15));
         apply_stimulus(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 9) < 7),
                        1'($urandom_range(0, 1)), a, $urandom);
      end

      $display("[TB] 256 writes then 256 reads at WAIT=0");
      apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0);
      idle_gap(2);
      b2b(1, 1'b1, 256, 1'b0);
      idle_gap(4);
      b2b(1, 1'b0, 256, 1'b0);
      idle_gap(4);
      @(negedge clk);
`ifdef XBUS_RAM_STATS_EN
      check_output("stats_wr", 32'(wr_count_b), 32'd256);
      check_output("stats_rd", 32'(rd_count_b), 32'd256);
`else
      check_output("stats_wr", 32'(wr_count_b), 32'd0);
      check_output("stats_rd", 32'(rd_count_b), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/xbus_ram.md
XBUS_RAM -- requirements
Module: xbus_ram

Interface
REQ-001 SHALL have parameter BASE_HI, default 14'h0010: addrin[21:8] value this responder decodes.
REQ-002 SHALL have parameter WAIT, default 2: wait cycles between request capture and ack, range 0..15.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port addrin, input, 22: request word address from initiator.
REQ-006 SHALL have port datain, input, 32: write data from initiator.
REQ-007 SHALL have port reqin, input, 1: request valid, held by initiator until it sees ackout.
REQ-008 SHALL have port writein, input, 1: 1 = write, 0 = read; qualified by reqin.
REQ-009 SHALL have port dataout, output, 32: read data, nonzero only in read ack cycle (bus is OR-combined).
REQ-010 SHALL have port ackout, output, 1: single-cycle transfer-complete strobe.
REQ-011 SHALL have port decodeout, output, 1: address-hit indication to arbiter.
REQ-012 SHALL have port rd_count, output, 16: completed-read count.
REQ-013 SHALL have port wr_count, output, 16: completed-write count.

Function
REQ-014 SHALL drive decodeout combinationally = reqin && (addrin[21:8] == BASE_HI), in every state.
REQ-015 SHALL hold 256 x 32 storage indexed by addrin[7:0].
REQ-016 SHALL implement states S_IDLE, S_WAIT, S_ACK, S_RECOV.
REQ-017 S_IDLE: on decode hit, latch addr[7:0], writein and datain; go to S_WAIT with counter loaded to WAIT; if WAIT==0, go straight to S_ACK.
REQ-018 S_WAIT: decrement counter each cycle; enter S_ACK on the cycle after counter reaches 1, so ack occurs exactly WAIT+1 cycles after the capture edge.
REQ-019 Read: storage word SHALL be registered into a read-hold register on the S_WAIT->S_ACK (or S_IDLE->S_ACK) edge; dataout = hold only while in S_ACK with latched write==0, else 0.
REQ-020 Write: storage word SHALL be updated with the latched data on the edge leaving S_ACK.
REQ-021 S_ACK: ackout=1 for exactly one cycle; then go to S_RECOV.
REQ-022 S_RECOV: ackout=0; one cycle unconditionally, then S_IDLE; prevents double-ack while initiator drops reqin.
REQ-023 A request still asserted in S_IDLE after S_RECOV SHALL be treated as a new transfer (back-to-back; min 3 cycles per transfer at WAIT=0).
REQ-024 Changes of addrin/datain/writein after capture SHALL be ignored until the next S_IDLE.
REQ-025 reqin deasserted mid-transfer (S_WAIT) SHALL NOT abort; transfer completes and ack is issued.
REQ-026 Non-matching addresses SHALL produce no decodeout, no ack, no state change.
REQ-027 Storage SHALL NOT be cleared by reset; contents undefined until written.

Reset
REQ-028 reset SHALL force state S_IDLE, counter 0, ackout 0, dataout 0, read-hold 0, rd_count 0, wr_count 0 on the next edge, overriding any transfer in progress; no pending write SHALL commit.

Configuration
REQ-029 With XBUS_RAM_STATS_EN defined: rd_count/wr_count SHALL increment (wrap at 16'hffff -> 0) on each read/write ack cycle.
REQ-030 Without XBUS_RAM_STATS_EN: rd_count and wr_count SHALL be constant 0 and no counter registers SHALL exist.

Structure
REQ-031 State encodings and the default BASE_HI SHALL live in shared package xbus_pkg, reused by the xbus initiators.
REQ-032 Storage SHALL be sub-module xbus_ram_array (256x32, 1 sync write port, 1 sync read port); FSM stays in xbus_ram.

Verification
REQ-033 Write addr 22'o0010012 (=14'h0010:8'h0a), data 32'hdeadbeef, WAIT=2 -> decodeout same cycle, ackout one pulse 3 cycles after capture, dataout 0 throughout.
REQ-034 Read same address -> ackout pulse with dataout 32'hdeadbeef in that cycle only; 0 before and after.
REQ-035 Request at addrin[21:8]=14'h0011 held 20 cycles -> decodeout 0, ackout never asserted.
REQ-036 WAIT=0, reqin held high for 4 back-to-back writes to addr 0..3 (data = addr) -> 4 ack pulses 3 cycles apart; readback returns 0,1,2,3.
REQ-037 reset asserted in S_WAIT of write of 32'h12345678 to addr 8'h05 (prior content 32'h0) -> no ack; later read of 8'h05 returns 32'h0.
REQ-038 With XBUS_RAM_STATS_EN: 256 writes then 256 reads -> wr_count=256, rd_count=256; without macro both stay 0.
